// File: rtl/loader_pkg.sv
// Shared definitions for the program-memory loader: FSM state encoding and frame layout.
package loader_pkg;

  typedef enum logic [2:0] {
    LD_HDR0  = 3'd0,
    LD_HDR1  = 3'd1,
    LD_DATA  = 3'd2,
    LD_DONE  = 3'd3,
    LD_ERROR = 3'd4
  } ld_state_e;

  // Frame starts with a 16-bit word count, MSB first.
  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_to_word.sv
// Big-endian byte-to-word assembler; word_valid strobes combinationally with the 4th byte.
module byte_to_word
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] shift;

  // The completed word is presented alongside the 4th byte so the caller can register it.
  assign word_valid = byte_valid && !clear && (idx == 2'(WORD_BYTES - 1));
  assign word       = {shift, byte_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= 2'd0;
      shift <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      shift <= 24'd0;
    end else if (byte_valid) begin
      idx   <= idx + 2'd1;
      shift <= {shift[15:0], byte_data};
    end
  end

endmodule

// File: rtl/pmem_loader.sv
// Loads a length-prefixed byte stream into pmem and holds the CPU in reset until done.
module pmem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [31:0]       pmem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] Capacity = 17'(2 ** ADDR_W);

  ld_state_e         state;
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] word_addr;
  logic [TmoW-1:0]   tmo_cnt;
  logic [15:0]       hdr_n;
  logic              last_word;
  logic              byte_accept;
  logic              asm_clear;
  logic              word_valid;
  logic [31:0]       word;

  assign hdr_n       = {n_words[15:8], rx_data};
  assign last_word   = (17'(words_loaded) + 17'd1) == {1'b0, n_words};
  assign byte_accept = rx_valid && !reload && (state == LD_DATA);
  // Holding the assembler clear outside DATA drops any partial word on reload or abort.
  assign asm_clear   = reload || (state != LD_DATA);

  byte_to_word u_byte_to_word (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (byte_accept),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= LD_HDR0;
      n_words      <= 16'd0;
      word_addr    <= '0;
      tmo_cnt      <= '0;
      pmem_we      <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= 32'd0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      pmem_we <= 1'b0;
      if (reload) begin
        state        <= LD_HDR0;
        n_words      <= 16'd0;
        word_addr    <= '0;
        tmo_cnt      <= '0;
        pmem_addr    <= '0;
        cpu_hold     <= 1'b1;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
      end else begin
        unique case (state)
          LD_HDR0: begin
            if (rx_valid) begin
              n_words[15:8] <= rx_data;
              tmo_cnt       <= '0;
              state         <= LD_HDR1;
            end
          end
          LD_HDR1: begin
            if (rx_valid) begin
              n_words[7:0] <= rx_data;
              tmo_cnt      <= '0;
              if (hdr_n == 16'd0) begin
                state     <= LD_DONE;
                cpu_hold  <= 1'b0;
                load_done <= 1'b1;
              end else if ({1'b0, hdr_n} > Capacity) begin
                state      <= LD_ERROR;
                load_error <= 1'b1;
              end else begin
                state     <= LD_DATA;
                word_addr <= '0;
              end
            end else if (tmo_cnt == TmoLast) begin
              state      <= LD_ERROR;
              load_error <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TmoW'(1);
            end
          end
          LD_DATA: begin
            if (rx_valid) begin
              tmo_cnt <= '0;
            end else if (tmo_cnt == TmoLast) begin
              state      <= LD_ERROR;
              load_error <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TmoW'(1);
            end
            if (word_valid) begin
              pmem_we      <= 1'b1;
              pmem_wdata   <= word;
              pmem_addr    <= word_addr;
              word_addr    <= word_addr + ADDR_W'(1);
              words_loaded <= words_loaded + (ADDR_W + 1)'(1);
              if (last_word) begin
                state     <= LD_DONE;
                cpu_hold  <= 1'b0;
                load_done <= 1'b1;
              end
            end
          end
          LD_DONE, LD_ERROR: ;
          default: begin
            state      <= LD_ERROR;
            load_error <= 1'b1;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: stimulus queues expected writes, a monitor checks them.
module tb_pmem_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned TMO = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          reload = 1'b0;
  logic          pmem_we;
  logic [AW-1:0] pmem_addr;
  logic [31:0]   pmem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  pmem_loader #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .reload       (reload),
    .pmem_we      (pmem_we),
    .pmem_addr    (pmem_addr),
    .pmem_wdata   (pmem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  // Write must appear in the cycle right after the 4th byte's accepting edge.
  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    exp_q.push_back('{addr: a, data: w, cyc: cyc});
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1 reload = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (pmem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                   pmem_addr, pmem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(pmem_addr), 32'(e.addr));
          chk("wr_data", pmem_wdata, e.data);
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", 32'(pmem_we), 32'd0);
    chk("rst_addr", 32'(pmem_addr), 32'd0);
    chk("rst_wdata", pmem_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_count", 32'(words_loaded), 32'd0);
    @(negedge clock) reset = 1'b1;

    // Two-word frame
    send_hdr(16'd2);
    send_word(4'd0, 32'h1234_5678);
    chk("t1_mid_done", 32'(load_done), 32'd0);
    chk("t1_mid_hold", 32'(cpu_hold), 32'd1);
    send_word(4'd1, 32'h9ABC_DEF0);
    idle(1);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_count", 32'(words_loaded), 32'd2);
    idle(2);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // Empty program
    pulse_reload();
    chk("t2_reload_hold", 32'(cpu_hold), 32'd1);
    chk("t2_reload_done", 32'(load_done), 32'd0);
    chk("t2_reload_count", 32'(words_loaded), 32'd0);
    send_hdr(16'd0);
    idle(1);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    chk("t2_count", 32'(words_loaded), 32'd0);

    // reload together with a byte in DONE: the 0x00 must be dropped, else N would read as 0
    @(negedge clock);
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge clock);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    chk("t3_done", 32'(load_done), 32'd0);
    send_hdr(16'd1);
    send_word(4'd0, 32'h5566_7788);
    idle(1);
    chk("t3_done_after", 32'(load_done), 32'd1);
    chk("t3_count", 32'(words_loaded), 32'd1);

    // N = 17 exceeds the 16-word memory
    pulse_reload();
    send_hdr(16'd17);
    chk("t4_err", 32'(load_error), 32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_done", 32'(load_done), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h5A);
    idle(2);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);
    chk("t4_err_hold", 32'(load_error), 32'd1);

    // N = 16 fills the memory exactly
    pulse_reload();
    send_hdr(16'd16);
    for (int i = 0; i < 16; i++) begin
      send_word(AW'(i), {8'(i), 8'(8'hF0 ^ 8'(i)), 8'(8'h3C + 8'(i)), 8'hA5});
    end
    idle(1);
    chk("t5_done", 32'(load_done), 32'd1);
    chk("t5_err", 32'(load_error), 32'd0);
    chk("t5_count", 32'(words_loaded), 32'd16);

    // Timeout after two data bytes
    pulse_reload();
    send_hdr(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) @(posedge clock);
    #1;
    chk("t6_err_early", 32'(load_error), 32'd0);
    @(posedge clock);
    #1;
    chk("t6_err", 32'(load_error), 32'd1);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    pulse_reload();
    chk("t6_reload_err", 32'(load_error), 32'd0);
    chk("t6_reload_hold", 32'(cpu_hold), 32'd1);
    send_hdr(16'd1);
    send_word(4'd0, 32'h1122_3344);
    idle(1);
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_err_after", 32'(load_error), 32'd0);

    // Asynchronous reset mid-transfer with a partial word pending
    pulse_reload();
    send_hdr(16'd3);
    send_word(4'd0, 32'hAABB_CCDD);
    send_byte(8'h77);
    send_byte(8'h66);
    #2 reset = 1'b0;
    #1;
    chk("t7_we", 32'(pmem_we), 32'd0);
    chk("t7_addr", 32'(pmem_addr), 32'd0);
    chk("t7_wdata", pmem_wdata, 32'd0);
    chk("t7_hold", 32'(cpu_hold), 32'd1);
    chk("t7_done", 32'(load_done), 32'd0);
    chk("t7_err", 32'(load_error), 32'd0);
    chk("t7_count", 32'(words_loaded), 32'd0);
    @(negedge clock) reset = 1'b1;
    send_hdr(16'd1);
    send_word(4'd0, 32'hDEAD_BEEF);
    idle(1);
    chk("t7_done_after", 32'(load_done), 32'd1);
    chk("t7_count_after", 32'(words_loaded), 32'd1);

    idle(2);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
